hiscore_io: RTL and testbench

- Initiator side of the game's high-score RAM port (hs_address/hs_data_in/hs_data_out/hs_write).
- The game PCB responds on that port. This block drives it on behalf of the MiSTer HPS.
- Translates the linear byte stream of a high-score file into game-RAM addresses using a range table. The table is downloaded as a config file.
- Restores scores on download; saves them on upload. Sits in the top level beside the ROM loader, sharing the ioctl bus.

---
 rtl/hiscore_pkg.sv | 23 ++
 rtl/hiscore_range_table.sv | 70 +++++++
 rtl/hiscore_io.sv | 164 ++++++++++++++++
 tb/tb_hiscore_io.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hiscore_pkg.sv
// Shared types for the high-score RAM bridge: FSM states, range table entry
// layout and the byte offsets of each field within a 4-byte table entry.
package hiscore_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOOKUP,
        WAIT_OK,
        WRITE,
        READ,
        DONE
    } hs_state_t;

    typedef struct packed {
        logic [15:0] addr;
        logic [7:0]  len_m1;
    } range_t;

    localparam logic [1:0] FLD_HI  = 2'd0;
    localparam logic [1:0] FLD_LO  = 2'd1;
    localparam logic [1:0] FLD_LEN = 2'd2;

endpackage

// File: rtl/hiscore_range_table.sv
// Range table captured from the config download, with running entry count and
// byte total, plus a combinational indexed read port for the lookup walk.
module hiscore_range_table
    import hiscore_pkg::*;
#(
    parameter int         MAX_RANGES = 16,
    parameter logic [7:0] CFG_INDEX  = 8'd3,
    localparam int        IW         = $clog2(MAX_RANGES)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [7:0]    ioctl_index,
    input  logic [24:0]   ioctl_addr,
    input  logic [7:0]    ioctl_data,
    input  logic          ioctl_wr,
    input  logic          ioctl_download,
    input  logic [IW-1:0] rd_idx,
    output range_t        rd_entry,
    output logic [4:0]    range_count,
    output logic [12:0]   total_bytes
);

    range_t        table_q [MAX_RANGES];
    logic          dl_q;
    logic          cfg_sel;
    logic          cfg_start;
    logic          cfg_wr;
    logic          in_range;
    logic [IW-1:0] ent;
    logic [4:0]    ent_cnt;

    assign cfg_sel   = (ioctl_index == CFG_INDEX);
    assign cfg_start = ioctl_download && !dl_q && cfg_sel;
    assign cfg_wr    = ioctl_wr && ioctl_download && cfg_sel;
    assign in_range  = (ioctl_addr[24:2] < 23'(MAX_RANGES));
    assign ent       = ioctl_addr[IW+1:2];
    assign ent_cnt   = 5'(ent) + 5'd1;
    assign rd_entry  = table_q[rd_idx];

    // Count and total only move on the length field; a fresh session clears them.
    always_ff @(posedge clk) begin
        if (reset) begin
            dl_q        <= 1'b0;
            range_count <= '0;
            total_bytes <= '0;
        end else begin
            dl_q <= ioctl_download;
            if (cfg_start) begin
                range_count <= '0;
                total_bytes <= '0;
            end else if (cfg_wr && in_range && ioctl_addr[1:0] == FLD_LEN) begin
                if (ent_cnt > range_count)
                    range_count <= ent_cnt;
                total_bytes <= total_bytes + 13'(ioctl_data) + 13'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (cfg_wr && in_range) begin
            case (ioctl_addr[1:0])
                FLD_HI:  table_q[ent].addr[15:8] <= ioctl_data;
                FLD_LO:  table_q[ent].addr[7:0]  <= ioctl_data;
                FLD_LEN: table_q[ent].len_m1     <= ioctl_data;
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/hiscore_io.sv
// Drives the game's high-score RAM port for the HPS: maps linear file offsets
// through the range table, restoring scores on download and saving on upload.
module hiscore_io
    import hiscore_pkg::*;
#(
    parameter int         MAX_RANGES = 16,
    parameter logic [7:0] CFG_INDEX  = 8'd3,
    parameter logic [7:0] DATA_INDEX = 8'd4,
    parameter int         RD_LATENCY = 2
) (
    input  logic        clk_49m,
    input  logic        reset,
    input  logic [7:0]  ioctl_index,
    input  logic [24:0] ioctl_addr,
    input  logic [7:0]  ioctl_data,
    input  logic        ioctl_wr,
    input  logic        ioctl_rd,
    input  logic        ioctl_download,
    input  logic        ioctl_upload,
    output logic [7:0]  ioctl_din,
    output logic        ioctl_wait,
    input  logic        access_ok,
    output logic [15:0] hs_address,
    output logic [7:0]  hs_data_in,
    input  logic [7:0]  hs_data_out,
    output logic        hs_write,
    output logic [4:0]  range_count,
    output logic [12:0] total_bytes
);

    localparam int IW = $clog2(MAX_RANGES);

    hs_state_t   state, state_n;
    logic        op_read, op_read_n;
    logic [7:0]  byte_q, byte_n;
    logic [24:0] off_q, off_n;
    logic [4:0]  idx_q, idx_n;
    logic [7:0]  lat_q, lat_n;
    logic [15:0] hs_address_n;
    logic [7:0]  hs_data_in_n;
    logic        hs_write_n;
    logic [7:0]  ioctl_din_n;
    logic        ioctl_wait_n;
    logic        wr_go;
    logic        rd_go;
    range_t      entry;

    hiscore_range_table #(
        .MAX_RANGES (MAX_RANGES),
        .CFG_INDEX  (CFG_INDEX)
    ) u_table (
        .clk            (clk_49m),
        .reset          (reset),
        .ioctl_index    (ioctl_index),
        .ioctl_addr     (ioctl_addr),
        .ioctl_data     (ioctl_data),
        .ioctl_wr       (ioctl_wr),
        .ioctl_download (ioctl_download),
        .rd_idx         (idx_q[IW-1:0]),
        .rd_entry       (entry),
        .range_count    (range_count),
        .total_bytes    (total_bytes)
    );

    assign wr_go = ioctl_wr && (ioctl_index == DATA_INDEX);
    assign rd_go = ioctl_rd && ioctl_upload && (ioctl_index == DATA_INDEX);

    always_ff @(posedge clk_49m) begin
        if (reset) begin
            state      <= IDLE;
            op_read    <= 1'b0;
            byte_q     <= '0;
            off_q      <= '0;
            idx_q      <= '0;
            lat_q      <= '0;
            hs_address <= '0;
            hs_data_in <= '0;
            hs_write   <= 1'b0;
            ioctl_din  <= '0;
            ioctl_wait <= 1'b0;
        end else begin
            state      <= state_n;
            op_read    <= op_read_n;
            byte_q     <= byte_n;
            off_q      <= off_n;
            idx_q      <= idx_n;
            lat_q      <= lat_n;
            hs_address <= hs_address_n;
            hs_data_in <= hs_data_in_n;
            hs_write   <= hs_write_n;
            ioctl_din  <= ioctl_din_n;
            ioctl_wait <= ioctl_wait_n;
        end
    end

    // DONE accepts strobes like IDLE since ioctl_wait is already low there.
    always_comb begin
        state_n      = state;
        op_read_n    = op_read;
        byte_n       = byte_q;
        off_n        = off_q;
        idx_n        = idx_q;
        lat_n        = lat_q;
        hs_address_n = hs_address;
        hs_data_in_n = hs_data_in;
        hs_write_n   = 1'b0;
        ioctl_din_n  = ioctl_din;
        ioctl_wait_n = ioctl_wait;
        case (state)
            IDLE, DONE: begin
                state_n = IDLE;
                if (wr_go || rd_go) begin
                    op_read_n    = !wr_go;
                    byte_n       = ioctl_data;
                    off_n        = ioctl_addr;
                    idx_n        = '0;
                    ioctl_wait_n = 1'b1;
                    state_n      = LOOKUP;
                end
            end
            LOOKUP: begin
                if (idx_q == range_count) begin
                    if (op_read)
                        ioctl_din_n = 8'h00;
                    ioctl_wait_n = 1'b0;
                    state_n      = DONE;
                end else if (off_q <= 25'(entry.len_m1)) begin
                    hs_address_n = entry.addr + off_q[15:0];
                    state_n      = WAIT_OK;
                end else begin
                    off_n = off_q - 25'(entry.len_m1) - 25'd1;
                    idx_n = idx_q + 5'd1;
                end
            end
            WAIT_OK: begin
                if (access_ok) begin
                    if (op_read) begin
                        lat_n   = '0;
                        state_n = READ;
                    end else begin
                        hs_data_in_n = byte_q;
                        hs_write_n   = 1'b1;
                        state_n      = WRITE;
                    end
                end
            end
            WRITE: begin
                ioctl_wait_n = 1'b0;
                state_n      = DONE;
            end
            READ: begin
                if (lat_q == 8'(RD_LATENCY - 1)) begin
                    ioctl_din_n  = hs_data_out;
                    ioctl_wait_n = 1'b0;
                    state_n      = DONE;
                end else begin
                    lat_n = lat_q + 8'd1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: tb/tb_hiscore_io.sv
// Scoreboard bench for hiscore_io: directed config/restore/save vectors push
// expected game-port events; a negedge monitor pops and compares them.
module tb_hiscore_io;

    localparam int K_PULSE  = 0;
    localparam int K_END_WR = 1;
    localparam int K_END_RD = 2;

    typedef struct {
        int          kind;
        logic [15:0] addr;
        logic [7:0]  data;
    } exp_t;

    logic        clk_49m = 1'b0;
    logic        reset;
    logic [7:0]  ioctl_index;
    logic [24:0] ioctl_addr;
    logic [7:0]  ioctl_data;
    logic        ioctl_wr;
    logic        ioctl_rd;
    logic        ioctl_download;
    logic        ioctl_upload;
    logic [7:0]  ioctl_din;
    logic        ioctl_wait;
    logic        access_ok;
    logic [15:0] hs_address;
    logic [7:0]  hs_data_in;
    logic [7:0]  hs_data_out;
    logic        hs_write;
    logic [4:0]  range_count;
    logic [12:0] total_bytes;

    int   n_checks = 0;
    int   n_fails  = 0;
    exp_t exp_q[$];
    logic prev_wait = 1'b0;
    logic [7:0] game_d1 = 8'h00;

    always #10 clk_49m = ~clk_49m;

    hiscore_io dut (
        .clk_49m        (clk_49m),
        .reset          (reset),
        .ioctl_index    (ioctl_index),
        .ioctl_addr     (ioctl_addr),
        .ioctl_data     (ioctl_data),
        .ioctl_wr       (ioctl_wr),
        .ioctl_rd       (ioctl_rd),
        .ioctl_download (ioctl_download),
        .ioctl_upload   (ioctl_upload),
        .ioctl_din      (ioctl_din),
        .ioctl_wait     (ioctl_wait),
        .access_ok      (access_ok),
        .hs_address     (hs_address),
        .hs_data_in     (hs_data_in),
        .hs_data_out    (hs_data_out),
        .hs_write       (hs_write),
        .range_count    (range_count),
        .total_bytes    (total_bytes)
    );

    function automatic logic [7:0] game_byte(input logic [15:0] a);
        if (a == 16'h4003)
            return 8'h7E;
        return a[7:0] ^ 8'h5A;
    endfunction

    // Game RAM answers two clocks after the address.
    always @(posedge clk_49m) begin
        game_d1     <= game_byte(hs_address);
        hs_data_out <= game_d1;
    end

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic expect_event(input int kind, input logic [15:0] addr, input logic [7:0] data);
        exp_t e;
        e.kind = kind;
        e.addr = addr;
        e.data = data;
        exp_q.push_back(e);
    endtask

    always @(negedge clk_49m) begin
        exp_t e;
        if (reset) begin
            prev_wait = 1'b0;
        end else begin
            if (hs_write) begin
                if (exp_q.size() == 0) begin
                    check_output("unexpected_hs_write", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check_output("event_order_pulse", 32'(e.kind), K_PULSE);
                    check_output("hs_address", hs_address, e.addr);
                    check_output("hs_data_in", hs_data_in, e.data);
                end
            end
            if (prev_wait && !ioctl_wait) begin
                if (exp_q.size() == 0) begin
                    check_output("unexpected_completion", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check_output("event_order_end", 32'(e.kind == K_PULSE), 32'd0);
                    if (e.kind == K_END_RD)
                        check_output("ioctl_din", ioctl_din, e.data);
                end
            end
            prev_wait = ioctl_wait;
        end
    end

    task automatic cfg_begin();
        @(negedge clk_49m);
        ioctl_index    = 8'd3;
        ioctl_download = 1'b0;
        ioctl_upload   = 1'b0;
        @(negedge clk_49m);
        ioctl_download = 1'b1;
    endtask

    task automatic cfg_write(input logic [24:0] addr, input logic [7:0] data);
        @(negedge clk_49m);
        ioctl_addr = addr;
        ioctl_data = data;
        ioctl_wr   = 1'b1;
        @(negedge clk_49m);
        ioctl_wr = 1'b0;
        check_output("cfg_wait_low", ioctl_wait, 1'b0);
    endtask

    task automatic cfg_entry(input int e, input logic [15:0] addr, input logic [7:0] len_m1);
        cfg_write(25'(e * 4 + 0), addr[15:8]);
        cfg_write(25'(e * 4 + 1), addr[7:0]);
        cfg_write(25'(e * 4 + 2), len_m1);
        cfg_write(25'(e * 4 + 3), 8'hEE);
    endtask

    task automatic cfg_end();
        @(negedge clk_49m);
        ioctl_download = 1'b0;
    endtask

    task automatic apply_stimulus(input logic is_rd, input logic [24:0] off, input logic [7:0] data);
        @(negedge clk_49m);
        ioctl_index = 8'd4;
        ioctl_addr  = off;
        ioctl_data  = data;
        ioctl_wr    = !is_rd;
        ioctl_rd    = is_rd;
        @(negedge clk_49m);
        ioctl_wr = 1'b0;
        ioctl_rd = 1'b0;
        check_output("wait_after_strobe", ioctl_wait, 1'b1);
    endtask

    task automatic wait_done(input string name);
        int k;
        for (k = 0; k < 200; k++) begin
            if (!ioctl_wait)
                break;
            @(negedge clk_49m);
        end
        if (k == 200)
            check_output(name, 32'd1, 32'd0);
        @(negedge clk_49m);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic stall_ok;
        reset          = 1'b1;
        ioctl_index    = 8'd0;
        ioctl_addr     = '0;
        ioctl_data     = '0;
        ioctl_wr       = 1'b0;
        ioctl_rd       = 1'b0;
        ioctl_download = 1'b0;
        ioctl_upload   = 1'b0;
        access_ok      = 1'b0;
        repeat (3) @(negedge clk_49m);
        check_output("rst_ioctl_wait", ioctl_wait, 1'b0);
        check_output("rst_hs_write", hs_write, 1'b0);
        check_output("rst_hs_address", hs_address, 16'h0000);
        check_output("rst_hs_data_in", hs_data_in, 8'h00);
        check_output("rst_ioctl_din", ioctl_din, 8'h00);
        check_output("rst_range_count", range_count, 5'd0);
        check_output("rst_total_bytes", total_bytes, 13'd0);
        reset = 1'b0;

        // Two-entry table: 16 bytes at 0x4000, 4 bytes at 0x4100
        cfg_begin();
        cfg_entry(0, 16'h4000, 8'h0F);
        cfg_entry(1, 16'h4100, 8'h03);
        cfg_end();
        @(negedge clk_49m);
        check_output("cfg_range_count", range_count, 5'd2);
        check_output("cfg_total_bytes", total_bytes, 13'd20);

        // Restore: offset 17 -> entry 1 offset 1
        ioctl_index    = 8'd4;
        ioctl_download = 1'b1;
        access_ok      = 1'b1;
        expect_event(K_PULSE, 16'h4101, 8'hA5);
        expect_event(K_END_WR, 16'h0000, 8'h00);
        apply_stimulus(1'b0, 25'd17, 8'hA5);
        wait_done("restore_timeout");

        // Save with a 50-clock access stall
        ioctl_download = 1'b0;
        ioctl_upload   = 1'b1;
        access_ok      = 1'b0;
        expect_event(K_END_RD, 16'h0000, 8'h7E);
        apply_stimulus(1'b1, 25'd3, 8'h00);
        stall_ok = 1'b1;
        repeat (50) begin
            @(negedge clk_49m);
            if (!ioctl_wait)
                stall_ok = 1'b0;
        end
        check_output("wait_held_in_stall", stall_ok, 1'b1);
        access_ok = 1'b1;
        wait_done("save_timeout");

        // Out-of-range read and write at offset 20 (table holds 20 bytes)
        expect_event(K_END_RD, 16'h0000, 8'h00);
        apply_stimulus(1'b1, 25'd20, 8'h00);
        wait_done("oor_read_timeout");
        ioctl_upload   = 1'b0;
        ioctl_download = 1'b1;
        expect_event(K_END_WR, 16'h0000, 8'h00);
        apply_stimulus(1'b0, 25'd20, 8'h99);
        wait_done("oor_write_timeout");
        ioctl_download = 1'b0;

        // Address wrap: 0xFFFE + 3 -> 0x0001
        cfg_begin();
        cfg_entry(0, 16'hFFFE, 8'h03);
        cfg_end();
        @(negedge clk_49m);
        check_output("wrap_range_count", range_count, 5'd1);
        check_output("wrap_total_bytes", total_bytes, 13'd4);
        ioctl_index    = 8'd4;
        ioctl_download = 1'b1;
        expect_event(K_PULSE, 16'h0001, 8'h3C);
        expect_event(K_END_WR, 16'h0000, 8'h00);
        apply_stimulus(1'b0, 25'd3, 8'h3C);
        wait_done("wrap_timeout");

        // Reset while parked in WAIT_OK must abort with no write
        access_ok = 1'b0;
        apply_stimulus(1'b0, 25'd0, 8'h55);
        repeat (3) @(negedge clk_49m);
        check_output("wait_before_reset", ioctl_wait, 1'b1);
        reset = 1'b1;
        @(negedge clk_49m);
        check_output("abort_ioctl_wait", ioctl_wait, 1'b0);
        check_output("abort_range_count", range_count, 5'd0);
        check_output("abort_total_bytes", total_bytes, 13'd0);
        check_output("abort_hs_address", hs_address, 16'h0000);
        reset          = 1'b0;
        ioctl_download = 1'b0;
        access_ok      = 1'b1;
        repeat (10) @(negedge clk_49m);
        check_output("abort_hs_write", hs_write, 1'b0);

        // New config session clears on the download rising edge
        cfg_begin();
        cfg_entry(0, 16'h1000, 8'h07);
        cfg_end();
        @(negedge clk_49m);
        check_output("pre_clear_count", range_count, 5'd1);
        check_output("pre_clear_total", total_bytes, 13'd8);
        cfg_begin();
        @(negedge clk_49m);
        check_output("clear_count", range_count, 5'd0);
        check_output("clear_total", total_bytes, 13'd0);
        cfg_write(25'd10, 8'h01);
        check_output("sparse_count", range_count, 5'd3);
        check_output("sparse_total", total_bytes, 13'd2);
        cfg_write(25'd66, 8'h05);
        check_output("dropped_count", range_count, 5'd3);
        check_output("dropped_total", total_bytes, 13'd2);
        cfg_write(25'd62, 8'h00);
        check_output("last_entry_count", range_count, 5'd16);
        check_output("last_entry_total", total_bytes, 13'd3);
        cfg_end();

        repeat (4) @(negedge clk_49m);
        check_output("scoreboard_drained", exp_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
